// File: rtl/dcache_responder.sv
// Direct-mapped, write-back data cache answering the Mem stage's dc_* request/ack
// interface. Single-word loads and stores are serviced from a per-set 512-bit line.
// A miss evicts a dirty victim and then refills the line from a beat-serial backing
// memory, at 8 x 64-bit beats per line. Misses are write-allocate.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   dc_req              request, held by the requester until dc_ack
//   dc_line_addr        line address (byte address [63:6]); index in the low bits
//   dc_word_select      32-bit word within the line
//   dc_data_to_cache    store data; only [31:0] is used
//   dc_read_write_n     1 = load, 0 = store
//   dc_ack              registered one-cycle completion pulse
//   dc_data_from_cache  {32'b0, word} for loads in the ack cycle, else 0
//   mem_req             backing-memory burst in progress
//   mem_line_addr       line address of the burst
//   mem_write           1 = write-back burst, 0 = refill burst
//   mem_wdata           write-back data for the current beat
//   mem_ready           beat handshake (write beat taken / read beat valid)
//   mem_rdata           refill beat data
module dcache_responder #(
   parameter int unsigned INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dc_req,
   input  logic [57:0] dc_line_addr,
   input  logic [3:0]  dc_word_select,
   input  logic [63:0] dc_data_to_cache,
   input  logic        dc_read_write_n,
   output logic        dc_ack,
   output logic [63:0] dc_data_from_cache,
   output logic        mem_req,
   output logic [57:0] mem_line_addr,
   output logic        mem_write,
   output logic [63:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [63:0] mem_rdata
);

   localparam int unsigned Sets    = 2 ** INDEX_BITS;
   localparam int unsigned TagBits = 58 - INDEX_BITS;

   typedef enum logic [2:0] {
      StIdle, StLookup, StWb, StWbGap, StFill, StResp, StDone
   } state_e;

   state_e state_q, state_d;

   // Line storage
   logic [Sets-1:0]    valid_q;
   logic [Sets-1:0]    dirty_q;
   logic [TagBits-1:0] tag_q  [Sets];
   logic [511:0]       data_q [Sets];

   // Latched request
   logic [57:0] addr_q;
   logic [3:0]  word_q;
   logic [31:0] wdata_q;
   logic        load_q;

   logic [2:0]  cnt_q;
   logic [57:0] mem_addr_q;
   logic        ack_q;
   logic [63:0] rdata_q;
   logic [31:0] load_word_q;

   logic [INDEX_BITS-1:0] idx;
   logic [TagBits-1:0]    req_tag;
   logic                  hit;
   logic                  victim_dirty;
   logic                  beat_done;
   logic                  last_beat;
   logic [511:0]          cur_line;
   logic [511:0]          base_line;
   logic [511:0]          acc_line;
   logic [31:0]           sel_word;
   logic                  unused_hi;

   assign unused_hi = ^dc_data_to_cache[63:32];

   assign idx          = addr_q[INDEX_BITS-1:0];
   assign req_tag      = addr_q[57:INDEX_BITS];
   assign cur_line     = data_q[idx];
   assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
   assign victim_dirty = valid_q[idx] && dirty_q[idx];

   // mem_req is decoded straight from the state register, so it is glitch-free and
   // mem_ready is ignored in every state other than WB/FILL.
   assign mem_req   = (state_q == StWb) || (state_q == StFill);
   assign mem_write = (state_q == StWb);
   assign beat_done = mem_req && mem_ready;
   assign last_beat = beat_done && (cnt_q == 3'd7);

   // Beat data only depends on state and cnt, so it holds through memory stalls.
   assign mem_wdata = mem_write ? cur_line[{cnt_q, 6'd0} +: 64] : '0;

   assign dc_ack             = ack_q;
   assign dc_data_from_cache = rdata_q;
   assign mem_line_addr      = mem_addr_q;

   // base_line: the line as it stands after this cycle's refill beat (if any).
   // acc_line: base_line with the pending store word merged in.
   always_comb begin
      base_line = cur_line;
      if (state_q == StFill) begin
         base_line[{cnt_q, 6'd0} +: 64] = mem_rdata;
      end
      acc_line = base_line;
      if (!load_q) begin
         acc_line[{word_q, 5'd0} +: 32] = wdata_q;
      end
      sel_word = base_line[{word_q, 5'd0} +: 32];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (dc_req) state_d = StLookup;
         StLookup: begin
            if (hit) begin
               state_d = StResp;
            end else if (victim_dirty) begin
               state_d = StWb;
            end else begin
               state_d = StFill;
            end
         end
         StWb:     if (last_beat) state_d = StWbGap;
         StWbGap:  state_d = StFill;
         StFill:   if (last_beat) state_d = StResp;
         StResp:   state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         dirty_q     <= '0;
         addr_q      <= '0;
         word_q      <= '0;
         wdata_q     <= '0;
         load_q      <= 1'b1;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         load_word_q <= '0;
      end else begin
         state_q <= state_d;
         // Ack and load data register out of RESP, so both appear in the DONE cycle.
         ack_q   <= (state_q == StResp);
         rdata_q <= ((state_q == StResp) && load_q) ? {32'd0, load_word_q} : '0;

         if ((state_q == StIdle) && dc_req) begin
            addr_q  <= dc_line_addr;
            word_q  <= dc_word_select;
            wdata_q <= dc_data_to_cache[31:0];
            load_q  <= dc_read_write_n;
         end

         // 3-bit counter wraps to 0 exactly as beat 7 completes.
         if (beat_done) begin
            cnt_q <= cnt_q + 3'd1;
         end

         if (state_q == StLookup) begin
            if (hit) begin
               load_word_q <= sel_word;
               if (!load_q) begin
                  dirty_q[idx] <= 1'b1;
               end
            end else if (victim_dirty) begin
               mem_addr_q <= {tag_q[idx], idx};
            end else begin
               mem_addr_q <= addr_q;
            end
         end

         if ((state_q == StWb) && last_beat) begin
            dirty_q[idx] <= 1'b0;
         end

         if (state_q == StWbGap) begin
            mem_addr_q <= addr_q;
         end

         if ((state_q == StFill) && last_beat) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= !load_q;
            load_word_q  <= sel_word;
         end
      end
   end

   // Tag and data arrays need no reset; valid_q qualifies them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if ((state_q == StLookup) && hit && !load_q) begin
            data_q[idx] <= acc_line;
         end
         if ((state_q == StFill) && beat_done) begin
            data_q[idx] <= last_beat ? acc_line : base_line;
            if (last_beat) begin
               tag_q[idx] <= req_tag;
            end
         end
      end
   end

endmodule
